chacha20_stream_decrypt: RTL and testbench

Receive-side ChaCha20 stream engine. It accepts a ciphertext byte stream (valid/ready/last), requests 64-byte keystream blocks from the shared ChaCha20 block-function core, and XORs each byte with the keystream to emit plaintext. It increments the block counter every 64 bytes. It sits between the link receiver and the application, as the counterpart of the byte-level encryption front end.

---
 rtl/chacha20_stream_decrypt.sv | 150 +++++++++++++++
 tb/tb_chacha20_stream_decrypt.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha20_stream_decrypt.sv
// Receive-side ChaCha20 stream engine: fetches 64-byte keystream blocks and XORs each ciphertext byte.
// Latency: one cycle from ct handshake to pt_valid. Backpressure: ct_ready = !pt_valid || pt_ready while streaming.
module chacha20_stream_decrypt (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [31:0]  init_counter,
    output logic         ks_req,
    output logic [31:0]  ks_counter,
    input  logic         ks_valid,
    input  logic [511:0] ks_block,
    input  logic [7:0]   ct_data,
    input  logic         ct_valid,
    input  logic         ct_last,
    output logic         ct_ready,
    output logic [7:0]   pt_data,
    output logic         pt_valid,
    output logic         pt_last,
    input  logic         pt_ready,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_STREAM,
        S_DRAIN,
        S_ERR
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    counter_q, counter_d;
    logic [5:0]     idx_q, idx_d;
    logic [511:0]   ks_buf_q;
    logic           ks_load;
    logic [7:0]     pt_data_q, pt_data_d;
    logic           pt_valid_q, pt_valid_d;
    logic           pt_last_q, pt_last_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic           ct_hs;
    logic           pt_hs;
    logic [7:0]     ks_byte;

    assign ks_byte  = ks_buf_q[{idx_q, 3'b000} +: 8];
    assign ct_ready = (state_q == S_STREAM) && (!pt_valid_q || pt_ready);
    assign ct_hs    = ct_valid && ct_ready;
    assign pt_hs    = pt_valid_q && pt_ready;

    assign ks_req     = (state_q == S_FETCH);
    assign ks_counter = counter_q;
    assign pt_data    = pt_data_q;
    assign pt_valid   = pt_valid_q;
    assign pt_last    = pt_last_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign err        = err_q;

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        idx_d      = idx_q;
        err_d      = err_q;
        done_d     = 1'b0;
        ks_load    = 1'b0;
        pt_data_d  = pt_data_q;
        pt_valid_d = pt_valid_q;
        pt_last_d  = pt_last_q;

        // Single output register: a new byte overwrites, otherwise it empties on acceptance.
        if (ct_hs) begin
            pt_data_d  = ct_data ^ ks_byte;
            pt_valid_d = 1'b1;
            pt_last_d  = ct_last;
        end else if (pt_hs) begin
            pt_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    counter_d = init_counter;
                    idx_d     = 6'd0;
                    err_d     = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                if (ks_valid) begin
                    ks_load = 1'b1;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (ct_hs) begin
                    idx_d = idx_q + 6'd1;
                    // The last byte wins over a block boundary, so no useless fetch follows it.
                    if (ct_last) begin
                        state_d = S_DRAIN;
                    end else if (idx_q == 6'd63) begin
                        if (counter_q == 32'hFFFF_FFFF) begin
                            err_d   = 1'b1;
                            state_d = S_ERR;
                        end else begin
                            counter_d = counter_q + 32'd1;
                            state_d   = S_FETCH;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (pt_hs && pt_last_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            counter_q  <= 32'd0;
            idx_q      <= 6'd0;
            ks_buf_q   <= '0;
            pt_data_q  <= 8'd0;
            pt_valid_q <= 1'b0;
            pt_last_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            idx_q      <= idx_d;
            if (ks_load) begin
                ks_buf_q <= ks_block;
            end
            pt_data_q  <= pt_data_d;
            pt_valid_q <= pt_valid_d;
            pt_last_q  <= pt_last_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_chacha20_stream_decrypt.sv
// Scoreboard bench for chacha20_stream_decrypt with a behavioural keystream core stub.
module tb_chacha20_stream_decrypt;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  init_counter = 32'd0;
    logic         ks_req;
    logic [31:0]  ks_counter;
    logic         ks_valid;
    logic [511:0] ks_block;
    logic [7:0]   ct_data = 8'd0;
    logic         ct_valid = 1'b0;
    logic         ct_last = 1'b0;
    logic         ct_ready;
    logic [7:0]   pt_data;
    logic         pt_valid;
    logic         pt_last;
    logic         pt_ready;
    logic         busy;
    logic         done;
    logic         err;

    chacha20_stream_decrypt dut (
        .clk(clk), .rst_n(rst_n), .start(start), .init_counter(init_counter),
        .ks_req(ks_req), .ks_counter(ks_counter), .ks_valid(ks_valid), .ks_block(ks_block),
        .ct_data(ct_data), .ct_valid(ct_valid), .ct_last(ct_last), .ct_ready(ct_ready),
        .pt_data(pt_data), .pt_valid(pt_valid), .pt_last(pt_last), .pt_ready(pt_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       last;
        logic [7:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  out_log[$];
    logic [31:0] req_ctrs[$];
    logic [7:0]  msg_ct[$];
    int          done_cnt = 0;
    int          n_vec = 0;
    int          n_fail = 0;
    int          ks_mode = 0;
    logic [31:0] rfc_base = 32'd1;
    bit          rand_rdy = 1'b0;

    string pt_txt = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";

    logic [7:0] rfc_ct [114] = '{
        8'h6e, 8'h2e, 8'h35, 8'h9a, 8'h25, 8'h68, 8'hf9, 8'h80, 8'h41, 8'hba, 8'h07, 8'h28, 8'hdd, 8'h0d, 8'h69, 8'h81,
        8'he9, 8'h7e, 8'h7a, 8'hec, 8'h1d, 8'h43, 8'h60, 8'hc2, 8'h0a, 8'h27, 8'haf, 8'hcc, 8'hfd, 8'h9f, 8'hae, 8'h0b,
        8'hf9, 8'h1b, 8'h65, 8'hc5, 8'h52, 8'h47, 8'h33, 8'hab, 8'h8f, 8'h59, 8'h3d, 8'hab, 8'hcd, 8'h62, 8'hb3, 8'h57,
        8'h16, 8'h39, 8'hd6, 8'h24, 8'he6, 8'h51, 8'h52, 8'hab, 8'h8f, 8'h53, 8'h0c, 8'h35, 8'h9f, 8'h08, 8'h61, 8'hd8,
        8'h07, 8'hca, 8'h0d, 8'hbf, 8'h50, 8'h0d, 8'h6a, 8'h61, 8'h56, 8'ha3, 8'h8e, 8'h08, 8'h8a, 8'h22, 8'hb6, 8'h5e,
        8'h52, 8'hbc, 8'h51, 8'h4d, 8'h16, 8'hcc, 8'hf8, 8'h06, 8'h81, 8'h8c, 8'he9, 8'h1a, 8'hb7, 8'h79, 8'h37, 8'h36,
        8'h5a, 8'hf9, 8'h0b, 8'hbf, 8'h74, 8'ha3, 8'h5b, 8'he6, 8'hb4, 8'h0b, 8'h8e, 8'hed, 8'hf2, 8'h78, 8'h5e, 8'h42,
        8'h87, 8'h4d
    };

    // Keystream byte idx of the block with counter ctr, as the stub core delivers it.
    function automatic logic [7:0] ks_model(input logic [31:0] ctr, input int idx);
        int j;
        case (ks_mode)
            1: begin
                j = int'(ctr - rfc_base) * 64 + idx;
                if (j >= 0 && j < 114) return rfc_ct[j] ^ 8'(pt_txt[j]);
                return 8'd0;
            end
            2: return 8'(idx) ^ {ctr[3:0], 4'h5};
            default: return 8'(idx);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Keystream core stub: answers a held request after three cycles with a one-cycle pulse.
    initial begin
        int lat;
        lat = 0;
        ks_valid = 1'b0;
        ks_block = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                lat = 0;
                ks_valid = 1'b0;
            end else if (ks_valid) begin
                ks_valid = 1'b0;
            end else if (ks_req) begin
                lat++;
                if (lat >= 3) begin
                    lat = 0;
                    for (int i = 0; i < 64; i++) ks_block[8*i +: 8] = ks_model(ks_counter, i);
                    ks_valid = 1'b1;
                end
            end else begin
                lat = 0;
            end
        end
    end

    initial begin
        pt_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pt_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on every pt handshake and checks stall rules.
    initial begin
        exp_t       e;
        logic       prev_stall;
        logic [7:0] prev_d;
        logic       prev_l;
        logic       prev_req;
        prev_stall = 1'b0;
        prev_d = 8'd0;
        prev_l = 1'b0;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_req = 1'b0;
            end else begin
                if (ks_req && !prev_req) req_ctrs.push_back(ks_counter);
                prev_req = ks_req;
                if (done) begin
                    done_cnt++;
                    chk("busy_low_with_done", 64'(busy), 64'd0);
                end
                if (pt_valid && pt_ready) begin
                    out_log.push_back(pt_data);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pt_byte", 64'(pt_data), 64'hx);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pt_data", 64'(pt_data), 64'(e.d));
                        chk("pt_last", 64'(pt_last), 64'(e.last));
                    end
                end
                if (pt_valid && !pt_ready) chk("ct_ready_in_stall", 64'(ct_ready), 64'd0);
                if (prev_stall) begin
                    chk("stall_data_stable", 64'(pt_data), 64'(prev_d));
                    chk("stall_last_stable", 64'(pt_last), 64'(prev_l));
                end
                prev_stall = pt_valid && !pt_ready;
                prev_d = pt_data;
                prev_l = pt_last;
            end
        end
    end

    task automatic reset_counts();
        out_log.delete();
        req_ctrs.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [31:0] ctr);
        @(posedge clk);
        #1;
        start = 1'b1;
        init_counter = ctr;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("ks_req_after_start", 64'(ks_req), 64'd1);
        chk("ks_counter_first", 64'(ks_counter), 64'(ctr));
    endtask

    // kind 1 expects the RFC plaintext; otherwise expected = ct ^ keystream model.
    task automatic send_msg(input logic [31:0] ctr0, input int kind, input bit with_last);
        int   n;
        int   w;
        exp_t e;
        n = msg_ct.size();
        for (int j = 0; j < n; j++) begin
            ct_data = msg_ct[j];
            ct_valid = 1'b1;
            ct_last = with_last && (j == n - 1);
            w = 0;
            forever begin
                @(negedge clk);
                if (ct_ready) break;
                w++;
                if (w > 2000) begin
                    chk("ct_accept_timeout", 64'(w), 64'd0);
                    ct_valid = 1'b0;
                    ct_last = 1'b0;
                    return;
                end
            end
            e.last = ct_last;
            e.d = (kind == 1) ? 8'(pt_txt[j]) : (msg_ct[j] ^ ks_model(ctr0 + 32'(j / 64), j % 64));
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        ct_valid = 1'b0;
        ct_last = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy) begin
            @(negedge clk);
            w++;
            if (w > 3000) begin
                chk("idle_timeout", 64'(w), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ks_req"}, 64'(ks_req), 64'd0);
        chk({tag, "_ks_counter"}, 64'(ks_counter), 64'd0);
        chk({tag, "_ct_ready"}, 64'(ct_ready), 64'd0);
        chk({tag, "_pt_data"}, 64'(pt_data), 64'd0);
        chk({tag, "_pt_valid"}, 64'(pt_valid), 64'd0);
        chk({tag, "_pt_last"}, 64'(pt_last), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        bit seen_rdy;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // RFC 8439 2.4.2 message, counter 1
        ks_mode = 1;
        reset_counts();
        msg_ct.delete();
        for (int j = 0; j < 114; j++) msg_ct.push_back(rfc_ct[j]);
        do_start(32'd1);
        send_msg(32'd1, 1, 1'b1);
        wait_idle();
        chk("rfc_out_count", 64'(out_log.size()), 64'd114);
        chk("rfc_first_byte", 64'(out_log[0]), 64'h4c);
        chk("rfc_req_count", 64'(req_ctrs.size()), 64'd2);
        chk("rfc_req_ctr0", 64'(req_ctrs[0]), 64'd1);
        chk("rfc_req_ctr1", 64'(req_ctrs[1]), 64'd2);
        chk("rfc_done_count", 64'(done_cnt), 64'd1);
        chk("rfc_sb_empty", 64'(exp_q.size()), 64'd0);

        // single byte 0xAA with last, stub keystream byte i = i
        ks_mode = 0;
        reset_counts();
        msg_ct.delete();
        msg_ct.push_back(8'hAA);
        do_start(32'd5);
        send_msg(32'd5, 0, 1'b1);
        wait_idle();
        chk("one_byte_pt", 64'(out_log[0]), 64'hAA);
        chk("one_byte_req_count", 64'(req_ctrs.size()), 64'd1);
        chk("one_byte_done_count", 64'(done_cnt), 64'd1);
        chk("one_byte_busy", 64'(busy), 64'd0);

        // exactly 64 bytes, last on byte 64: one fetch, then drain
        reset_counts();
        msg_ct.delete();
        for (int j = 0; j < 64; j++) msg_ct.push_back(8'(j * 7 + 3));
        do_start(32'd20);
        send_msg(32'd20, 0, 1'b1);
        @(negedge clk);
        chk("b64_drain_ks_req", 64'(ks_req), 64'd0);
        chk("b64_drain_ct_ready", 64'(ct_ready), 64'd0);
        chk("b64_drain_busy", 64'(busy), 64'd1);
        wait_idle();
        chk("b64_req_count", 64'(req_ctrs.size()), 64'd1);
        chk("b64_byte63", 64'(out_log[63]), 64'(msg_ct[63] ^ 8'h3f));
        chk("b64_done_count", 64'(done_cnt), 64'd1);

        // 200 bytes with random pt_ready, counter-dependent keystream
        ks_mode = 2;
        rand_rdy = 1'b1;
        reset_counts();
        msg_ct.delete();
        for (int j = 0; j < 200; j++) msg_ct.push_back(8'($urandom));
        do_start(32'h10);
        send_msg(32'h10, 0, 1'b1);
        wait_idle();
        rand_rdy = 1'b0;
        chk("rnd_out_count", 64'(out_log.size()), 64'd200);
        chk("rnd_req_count", 64'(req_ctrs.size()), 64'd4);
        chk("rnd_req_ctr3", 64'(req_ctrs[3]), 64'h13);
        chk("rnd_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("rnd_done_count", 64'(done_cnt), 64'd1);

        // counter exhaustion on a 65-byte message
        ks_mode = 0;
        reset_counts();
        msg_ct.delete();
        for (int j = 0; j < 64; j++) msg_ct.push_back(8'(255 - j));
        do_start(32'hFFFF_FFFF);
        send_msg(32'hFFFF_FFFF, 0, 1'b0);
        ct_data = 8'h55;
        ct_valid = 1'b1;
        ct_last = 1'b1;
        seen_rdy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ct_ready) seen_rdy = 1'b1;
        end
        chk("exh_byte65_refused", 64'(seen_rdy), 64'd0);
        chk("exh_err", 64'(err), 64'd1);
        chk("exh_ct_ready", 64'(ct_ready), 64'd0);
        chk("exh_ks_req", 64'(ks_req), 64'd0);
        chk("exh_busy", 64'(busy), 64'd1);
        chk("exh_req_count", 64'(req_ctrs.size()), 64'd1);
        chk("exh_out_count", 64'(out_log.size()), 64'd64);
        chk("exh_sb_empty", 64'(exp_q.size()), 64'd0);
        ct_valid = 1'b0;
        ct_last = 1'b0;
        reset_counts();
        msg_ct.delete();
        msg_ct.push_back(8'h33);
        do_start(32'd0);
        chk("exh_err_cleared", 64'(err), 64'd0);
        send_msg(32'd0, 0, 1'b1);
        wait_idle();
        chk("exh_restart_done", 64'(done_cnt), 64'd1);
        chk("exh_restart_out", 64'(out_log[0]), 64'h33);

        // asynchronous reset at byte 30 of a stream, then a clean message
        reset_counts();
        msg_ct.delete();
        for (int j = 0; j < 30; j++) msg_ct.push_back(8'(j + 100));
        do_start(32'd7);
        send_msg(32'd7, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_counts();
        msg_ct.delete();
        for (int j = 0; j < 10; j++) msg_ct.push_back(8'(j * 13 + 1));
        do_start(32'd9);
        send_msg(32'd9, 0, 1'b1);
        wait_idle();
        chk("post_rst_out_count", 64'(out_log.size()), 64'd10);
        chk("post_rst_byte9", 64'(out_log[9]), 64'(msg_ct[9] ^ 8'd9));
        chk("post_rst_done", 64'(done_cnt), 64'd1);
        chk("post_rst_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
